// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pkg
//  Purpose  : Shared defaults and helpers for the nested interrupt controller
//             family: default source count, priority width, nesting depth,
//             vector table base/stride and the vector address computation.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

   localparam int          DEF_NUM_IRQ    = 16;
   localparam int          DEF_PRIO_W     = 3;
   localparam int          DEF_NEST_DEPTH = 4;
   localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_1000;
   localparam int          DEF_VEC_STRIDE = 4;

   // Vector table entry for a source id.
   function automatic logic [31:0] calc_vector(
      input logic [31:0] base,
      input logic [31:0] stride,
      input logic [31:0] id
   );
      return base + (id * stride);
   endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_arb.sv
`default_nettype none
// ============================================================================
//  Module   : irq_prio_arb
//  Purpose  : Combinational priority selector. Among all eligible sources it
//             picks the one with the highest priority value; equal priorities
//             resolve to the lowest source index.
//  Ports    : eligible  - per-source eligibility
//             prio      - packed priorities, source i at [i*PRIO_W +: PRIO_W]
//             win_id    - selected source index (0 when none)
//             win_prio  - priority of the selected source (0 when none)
//             win_valid - at least one source is eligible
//  Revision : 1.0 - initial release
// ============================================================================
module irq_prio_arb #(
   parameter int NUM_IRQ = 16,
   parameter int PRIO_W  = 3,
   parameter int IDW     = $clog2(NUM_IRQ)
)(
   input  logic [NUM_IRQ-1:0]        eligible,
   input  logic [NUM_IRQ*PRIO_W-1:0] prio,
   output logic [IDW-1:0]            win_id,
   output logic [PRIO_W-1:0]         win_prio,
   output logic                      win_valid
);

   logic [IDW-1:0]    w_best_id;
   logic [PRIO_W-1:0] w_best_prio;
   logic              w_found;

   // Ascending scan with a strict ">" so an equal priority found later never
   // displaces an earlier (lower-index) winner.
   always_comb begin
      w_best_id   = '0;
      w_best_prio = '0;
      w_found     = 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (eligible[i] && (!w_found || (prio[i*PRIO_W +: PRIO_W] > w_best_prio))) begin
            w_found     = 1'b1;
            w_best_id   = IDW'(i);
            w_best_prio = prio[i*PRIO_W +: PRIO_W];
         end
      end
   end

   assign win_id    = w_best_id;
   assign win_prio  = w_best_prio;
   assign win_valid = w_found;

endmodule
`default_nettype wire

// File: rtl/irq_nested_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_nested_ctrl
//  Purpose  : Nested interrupt controller. Latches edge requests (or follows
//             level requests), arbitrates the highest-priority pending source
//             that outranks the interrupt in service, keeps in-service
//             priorities on a nesting stack popped by end-of-interrupt and
//             presents a registered request/vector to the CPU.
//  Ports    : clk, reset_n       - clock, async active-low reset
//             irq_in             - request lines (synchronous to clk)
//             irq_mask           - 1 = source masked
//             irq_edge_sel       - 1 = rising-edge, 0 = level
//             irq_prio           - packed per-source priorities
//             cpu_ack / cpu_eoi  - CPU accept / end-of-interrupt
//             int_valid, irq_id, vector_addr - presented interrupt
//             irq_ack            - one-cycle one-hot ack pulse to the source
//             active_prio        - priority in service (0 when idle)
//             nest_level, stack_full - stack occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module irq_nested_ctrl
   import irq_pkg::*;
#(
   parameter int          NUM_IRQ    = DEF_NUM_IRQ,
   parameter int          PRIO_W     = DEF_PRIO_W,
   parameter int          NEST_DEPTH = DEF_NEST_DEPTH,
   parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
   parameter int          VEC_STRIDE = DEF_VEC_STRIDE,
   parameter int          IDW        = $clog2(NUM_IRQ),
   parameter int          LVW        = $clog2(NEST_DEPTH + 1)
)(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_IRQ-1:0]        irq_in,
   input  logic [NUM_IRQ-1:0]        irq_mask,
   input  logic [NUM_IRQ-1:0]        irq_edge_sel,
   input  logic [NUM_IRQ*PRIO_W-1:0] irq_prio,
   input  logic                      cpu_ack,
   input  logic                      cpu_eoi,
   output logic                      int_valid,
   output logic [IDW-1:0]            irq_id,
   output logic [31:0]               vector_addr,
   output logic [NUM_IRQ-1:0]        irq_ack,
   output logic [PRIO_W-1:0]         active_prio,
   output logic [LVW-1:0]            nest_level,
   output logic                      stack_full
);

   // ---------------------------------------------------------------- state
   logic [NUM_IRQ-1:0] r_prev_in;
   logic [NUM_IRQ-1:0] r_pend_edge;
   logic [PRIO_W-1:0]  r_stack_prio [NEST_DEPTH];
   logic [LVW-1:0]     r_level;
   logic               r_int_valid;
   logic [IDW-1:0]     r_irq_id;
   logic [PRIO_W-1:0]  r_irq_prio;
   logic [NUM_IRQ-1:0] r_irq_ack;

   // ---------------------------------------------------------------- wires
   logic [PRIO_W-1:0]  w_prio [NUM_IRQ];
   logic [NUM_IRQ-1:0] w_pending;
   logic [NUM_IRQ-1:0] w_eligible;
   logic [NUM_IRQ-1:0] w_ack_hot;
   logic [PRIO_W-1:0]  w_active_prio;
   logic               w_empty;
   logic               w_full;
   logic               w_accept;
   logic               w_pop;
   logic               w_wr_en;
   logic [LVW-1:0]     w_wr_idx;
   logic [IDW-1:0]     w_win_id;
   logic [PRIO_W-1:0]  w_win_prio;
   logic               w_win_valid;

   assign w_empty  = (r_level == '0);
   assign w_full   = (r_level == LVW'(NEST_DEPTH));
   assign w_accept = cpu_ack & r_int_valid;
   assign w_pop    = cpu_eoi & ~w_empty;

   // Per-source unpack, pending view, eligibility and ack one-hot.
   for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
      assign w_prio[gi]     = irq_prio[gi*PRIO_W +: PRIO_W];
      // Edge sources use the latched bit; level sources follow the line.
      assign w_pending[gi]  = irq_edge_sel[gi] ? r_pend_edge[gi] : irq_in[gi];
      assign w_eligible[gi] = w_pending[gi] & ~irq_mask[gi] &
                              (w_empty | (w_prio[gi] > w_active_prio));
      assign w_ack_hot[gi]  = w_accept & (r_irq_id == IDW'(gi));
   end

   // Priority of the top-of-stack entry; 0 while idle.
   always_comb begin
      w_active_prio = '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
         if (r_level == LVW'(i + 1)) begin
            w_active_prio = r_stack_prio[i];
         end
      end
   end

   irq_prio_arb #(
      .NUM_IRQ (NUM_IRQ),
      .PRIO_W  (PRIO_W),
      .IDW     (IDW)
   ) u_arb (
      .eligible  (w_eligible),
      .prio      (irq_prio),
      .win_id    (w_win_id),
      .win_prio  (w_win_prio),
      .win_valid (w_win_valid)
   );

   // ---------------------------------------------------------------- edges
   // A rising edge in the ack cycle re-arms the bit, so set wins over clear.
   // Bits of level-configured sources are held at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev_in   <= '0;
         r_pend_edge <= '0;
      end else begin
         r_prev_in   <= irq_in;
         r_pend_edge <= irq_edge_sel &
                        ((irq_in & ~r_prev_in) | (r_pend_edge & ~w_ack_hot));
      end
   end

   // ---------------------------------------------------------------- stack
   // Only the priority of stacked entries influences arbitration and the
   // outputs, so that is what each slot stores. Ack together with EOI
   // overwrites the top slot instead of push+pop.
   assign w_wr_en  = w_accept & (w_pop | ~w_full);
   assign w_wr_idx = w_pop ? (r_level - LVW'(1)) : r_level;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NEST_DEPTH; i++) begin
            r_stack_prio[i] <= '0;
         end
         r_level <= '0;
      end else begin
         for (int i = 0; i < NEST_DEPTH; i++) begin
            if (w_wr_en && (w_wr_idx == LVW'(i))) begin
               r_stack_prio[i] <= r_irq_prio;
            end
         end
         if (w_accept && !w_pop && !w_full) begin
            r_level <= r_level + LVW'(1);
         end else if (w_pop && !w_accept) begin
            r_level <= r_level - LVW'(1);
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   // The cycle after an accepted ack is a bubble: the stack has not yet been
   // updated when this edge arbitrates, so the result would be stale.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_int_valid <= 1'b0;
         r_irq_id    <= '0;
         r_irq_prio  <= '0;
         r_irq_ack   <= '0;
      end else begin
         r_irq_ack <= w_ack_hot;
         if (w_win_valid && !w_full && !w_accept) begin
            r_int_valid <= 1'b1;
            r_irq_id    <= w_win_id;
            r_irq_prio  <= w_win_prio;
         end else begin
            r_int_valid <= 1'b0;
         end
      end
   end

   assign int_valid   = r_int_valid;
   assign irq_id      = r_irq_id;
   assign vector_addr = calc_vector(VEC_BASE, 32'(VEC_STRIDE), 32'(r_irq_id));
   assign irq_ack     = r_irq_ack;
   assign active_prio = w_active_prio;
   assign nest_level  = r_level;
   assign stack_full  = w_full;

endmodule
`default_nettype wire

// File: tb/tb_irq_nested_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_nested_ctrl
//  Purpose  : Self-checking bench for irq_nested_ctrl. A queue-based reference
//             model advances alongside the design; directed scenarios and a
//             randomized phase are compared against it every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_nested_ctrl;

   localparam int N   = 16;
   localparam int PW  = 3;
   localparam int D   = 4;
   localparam int IDW = 4;
   localparam int LVW = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [N-1:0]      irq_in;
   logic [N-1:0]      irq_mask;
   logic [N-1:0]      irq_edge_sel;
   logic [N*PW-1:0]   irq_prio;
   logic              cpu_ack;
   logic              cpu_eoi;
   logic              int_valid;
   logic [IDW-1:0]    irq_id;
   logic [31:0]       vector_addr;
   logic [N-1:0]      irq_ack;
   logic [PW-1:0]     active_prio;
   logic [LVW-1:0]    nest_level;
   logic              stack_full;

   always #5 clk = ~clk;

   irq_nested_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .irq_in       (irq_in),
      .irq_mask     (irq_mask),
      .irq_edge_sel (irq_edge_sel),
      .irq_prio     (irq_prio),
      .cpu_ack      (cpu_ack),
      .cpu_eoi      (cpu_eoi),
      .int_valid    (int_valid),
      .irq_id       (irq_id),
      .vector_addr  (vector_addr),
      .irq_ack      (irq_ack),
      .active_prio  (active_prio),
      .nest_level   (nest_level),
      .stack_full   (stack_full)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   logic [N-1:0] m_prev;
   logic [N-1:0] m_pend;
   int           m_stk[$];     // priorities of in-service interrupts
   bit           m_valid;
   int           m_id;
   int           m_pprio;
   logic [N-1:0] m_ack;

   function automatic int prio_of(input int i);
      return int'(irq_prio[i*PW +: PW]);
   endfunction

   task automatic model_reset();
      m_prev  = '0;
      m_pend  = '0;
      m_stk.delete();
      m_valid = 1'b0;
      m_id    = 0;
      m_pprio = 0;
      m_ack   = '0;
   endtask

   // Computes the state after the coming clock edge from current inputs.
   task automatic model_step();
      int  active, best, bestp;
      bit  empty, full, acc, pop, pend;
      if (!reset_n) begin
         model_reset();
         return;
      end
      empty  = (m_stk.size() == 0);
      full   = (m_stk.size() == D);
      active = empty ? 0 : m_stk[m_stk.size()-1];
      best   = -1;
      bestp  = -1;
      for (int i = 0; i < N; i++) begin
         pend = irq_edge_sel[i] ? m_pend[i] : irq_in[i];
         if (pend && !irq_mask[i] && (empty || prio_of(i) > active) && prio_of(i) > bestp) begin
            best  = i;
            bestp = prio_of(i);
         end
      end
      acc = cpu_ack && m_valid;
      pop = cpu_eoi && !empty;
      if (acc && pop)      m_stk[m_stk.size()-1] = m_pprio;
      else if (acc)        m_stk.push_back(m_pprio);
      else if (pop)        void'(m_stk.pop_back());
      for (int i = 0; i < N; i++) begin
         m_pend[i] = irq_edge_sel[i] &&
                     ((irq_in[i] && !m_prev[i]) || (m_pend[i] && !(acc && m_id == i)));
      end
      m_ack = '0;
      if (acc) m_ack[m_id] = 1'b1;
      if (best >= 0 && !full && !acc) begin
         m_valid = 1'b1;
         m_id    = best;
         m_pprio = bestp;
      end else begin
         m_valid = 1'b0;
      end
      m_prev = irq_in;
   endtask

   task automatic compare_all();
      int sz;
      sz = m_stk.size();
      check("int_valid",   int_valid,   m_valid);
      check("irq_id",      irq_id,      m_id);
      check("vector_addr", vector_addr, 32'h0000_1000 + m_id * 4);
      check("irq_ack",     irq_ack,     m_ack);
      check("active_prio", active_prio, (sz == 0) ? 0 : m_stk[sz-1]);
      check("nest_level",  nest_level,  sz);
      check("stack_full",  stack_full,  sz == D);
   endtask

   // One clock: model advances, DUT clocks, both compared at the falling edge.
   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_prio(input int i, input int p);
      irq_prio[i*PW +: PW] = PW'(p);
   endtask

   task automatic pulse_ack();
      cpu_ack = 1'b1;
      step();
      cpu_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      cpu_eoi = 1'b1;
      step();
      cpu_eoi = 1'b0;
   endtask

   // Watchdog: the run is a fixed-length script; this only fires on a hang.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n      = 1'b0;
      irq_in       = '0;
      irq_mask     = '0;
      irq_edge_sel = '1;
      irq_prio     = '0;
      cpu_ack      = 1'b0;
      cpu_eoi      = 1'b0;
      model_reset();
      @(negedge clk);
      compare_all();
      check("reset_vector", vector_addr, 32'h0000_1000);
      @(negedge clk);
      reset_n = 1'b1;
      step();

      // Edge source 3, prio 2, two-cycle latency then ack.
      set_prio(3, 2);
      irq_in[3] = 1'b1;
      step();
      check("edge_lat_k", int_valid, 0);
      step();
      check("edge_valid", int_valid, 1);
      check("edge_id", irq_id, 3);
      check("edge_vec", vector_addr, 32'h0000_100C);
      irq_in[3] = 1'b0;
      pulse_ack();
      check("ack_pulse", irq_ack, 16'h0008);
      check("ack_level", nest_level, 1);
      check("ack_aprio", active_prio, 2);
      step();
      check("ack_pulse_end", irq_ack, 16'h0000);

      // Nesting: 7 (prio 5) preempts, 1 (prio 2) blocked until idle.
      set_prio(7, 5);
      irq_in[7] = 1'b1;
      step(); step();
      check("nest_id", irq_id, 7);
      irq_in[7] = 1'b0;
      pulse_ack();
      check("nest_level2", nest_level, 2);
      check("nest_aprio5", active_prio, 5);
      set_prio(1, 2);
      irq_in[1] = 1'b1;
      step(); step();
      check("blocked_eq_prio", int_valid, 0);
      irq_in[1] = 1'b0;
      pulse_eoi();
      check("eoi_aprio2", active_prio, 2);
      step();
      check("still_blocked", int_valid, 0);
      pulse_eoi();
      check("eoi_empty", nest_level, 0);
      step();
      check("idle_present", int_valid, 1);
      check("idle_id", irq_id, 1);
      pulse_ack();
      pulse_eoi();

      // Tie at prio 6: lowest index first.
      set_prio(4, 6);
      set_prio(9, 6);
      irq_in[4] = 1'b1;
      irq_in[9] = 1'b1;
      step(); step();
      check("tie_id", irq_id, 4);
      irq_in[4] = 1'b0;
      irq_in[9] = 1'b0;
      pulse_ack();
      pulse_eoi();
      step();
      check("tie_second", irq_id, 9);
      check("tie_second_v", int_valid, 1);
      pulse_ack();
      pulse_eoi();

      // Fill the stack with prios 1,3,5,7.
      set_prio(10, 1); set_prio(11, 3); set_prio(12, 5); set_prio(13, 7);
      for (int k = 10; k <= 13; k++) begin
         irq_in[k] = 1'b1;
         step(); step();
         pulse_ack();
         irq_in[k] = 1'b0;
      end
      check("full_flag", stack_full, 1);
      check("full_level", nest_level, 4);
      set_prio(2, 7);
      irq_in[2] = 1'b1;
      step(); step();
      check("full_no_valid", int_valid, 0);
      irq_in[2] = 1'b0;
      pulse_eoi();
      check("full_cleared", stack_full, 0);
      cpu_eoi = 1'b1;
      step(); step(); step();
      cpu_eoi = 1'b0;
      step();
      pulse_ack();
      pulse_eoi();

      // Level source 5 held through ack, re-presented after EOI, then masked.
      irq_edge_sel[5] = 1'b0;
      set_prio(5, 4);
      irq_in[5] = 1'b1;
      step();
      check("level_lat", int_valid, 1);
      check("level_id", irq_id, 5);
      pulse_ack();
      step();
      check("level_blocked", int_valid, 0);
      pulse_eoi();
      step();
      check("level_repres", int_valid, 1);
      irq_mask[5] = 1'b1;
      step();
      check("level_masked", int_valid, 0);
      irq_mask[5] = 1'b0;
      irq_in[5]   = 1'b0;
      step();

      // Simultaneous ack+eoi at level 2, then async reset mid-service.
      irq_in[3] = 1'b1; step(); step(); pulse_ack(); irq_in[3] = 1'b0;
      irq_in[7] = 1'b1; step(); step(); pulse_ack(); irq_in[7] = 1'b0;
      set_prio(8, 6);
      irq_in[8] = 1'b1;
      step(); step();
      check("swap_pres", irq_id, 8);
      cpu_ack = 1'b1;
      cpu_eoi = 1'b1;
      step();
      cpu_ack = 1'b0;
      cpu_eoi = 1'b0;
      check("swap_level", nest_level, 2);
      check("swap_aprio", active_prio, 6);
      check("swap_ack", irq_ack, 16'h0100);
      irq_in  = '0;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("async_level", nest_level, 0);
      check("async_aprio", active_prio, 0);
      check("async_ack", irq_ack, 0);
      compare_all();
      step(); step();
      reset_n = 1'b1;
      step();

      // Randomized phase.
      for (int i = 0; i < N; i++) begin
         irq_edge_sel[i] = 1'($urandom_range(0, 1));
         set_prio(i, $urandom_range(0, 7));
      end
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0)  irq_in[i]   = ~irq_in[i];
            if ($urandom_range(0, 63) == 0) irq_mask[i] = ~irq_mask[i];
         end
         if ($urandom_range(0, 15) == 0) set_prio($urandom_range(0, N-1), $urandom_range(0, 7));
         cpu_ack = m_valid ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
         cpu_eoi = ($urandom_range(0, 4) == 0);
         step();
      end
      cpu_ack = 1'b0;
      cpu_eoi = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
